// File: rtl/periph_bus_master.sv
// Peripheral bus initiator. Core stores are posted through a small FIFO that drains one entry per cycle.
// Core loads wait until all earlier stores are on the bus, then issue one read and return its data.
module periph_bus_master #(
    parameter int WBUF_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic [31:0] sys_w_addr,
    output logic [31:0] sys_w_line,
    output logic        sys_w,
    output logic [31:0] sys_r_addr,
    output logic        sys_r,
    input  logic [31:0] sys_r_line
);

    localparam int PW   = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(RD_LAT + 1) + 1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAITW,
        R_ISSUE,
        R_LAT
    } rstate_t;

    rstate_t         r_state;
    rstate_t         w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [31:0]     r_ld_addr;

    logic [31:0]     r_fifo_addr [WBUF_DEPTH];
    logic [31:0]     r_fifo_data [WBUF_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CNTW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ld_acc;
    logic w_issue;
    logic w_done;

    assign w_full  = (r_count == CNTW'(WBUF_DEPTH));
    assign w_empty = (r_count == '0);

    // Ready looks only at current state; reset forces it low so every output reads 0 in reset.
    assign cpu_ready = !rst && (r_state == R_IDLE) && (cpu_we ? !w_full : 1'b1);

    assign w_push   = cpu_req && cpu_ready && cpu_we;
    assign w_pop    = !w_empty;
    assign w_ld_acc = cpu_req && cpu_ready && !cpu_we;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= cpu_addr;
            r_fifo_data[r_wptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            sys_w      <= 1'b0;
            sys_w_addr <= '0;
            sys_w_line <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr     <= r_rptr + PW'(1);
                sys_w      <= 1'b1;
                sys_w_addr <= r_fifo_addr[r_rptr];
                sys_w_line <= r_fifo_data[r_rptr];
            end else begin
                sys_w <= 1'b0;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

    // Read issue also waits for sys_w to fall so the last posted store is fully on the bus first.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (w_ld_acc) begin
                    w_state_next = R_WAITW;
                end
            end
            R_WAITW: begin
                if (w_empty && !sys_w) begin
                    w_issue      = 1'b1;
                    w_state_next = R_ISSUE;
                end
            end
            R_ISSUE: begin
                w_cnt_next   = CW'(RD_LAT);
                w_state_next = R_LAT;
            end
            R_LAT: begin
                if (r_cnt == '0) begin
                    w_done       = 1'b1;
                    w_state_next = R_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            r_ld_addr  <= '0;
            sys_r      <= 1'b0;
            sys_r_addr <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            sys_r      <= w_issue;
            cpu_rvalid <= w_done;
            if (w_ld_acc) begin
                r_ld_addr <= cpu_addr;
            end
            if (w_issue) begin
                sys_r_addr <= r_ld_addr;
            end
            if (w_done) begin
                cpu_rdata <= sys_r_line;
            end
        end
    end

endmodule
